mult_div_unit: RTL and testbench
================================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 Parameter MDU_CYCLES, default 32, number of iteration cycles in CALC.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_b  input  1  reset; synchronous, active-high; port name kept from codebase despite _b suffix.
REQ-004 start  input  1  EX-stage request; sampled only in IDLE or DONE.
REQ-005 op  input  2  MDU_MULT=00, MDU_MULTU=01, MDU_DIV=10, MDU_DIVU=11.
REQ-006 rs_data  input  32  multiplicand / dividend, from ID/EX stage register.
REQ-007 rt_data  input  32  multiplier / divisor, from ID/EX stage register.
REQ-008 flush  input  1  abort in-flight operation (branch/halt squash).
REQ-009 busy  output  1  high in CALC and SIGN.
REQ-010 stall_req  output  1  combinational; busy OR (start AND state in {IDLE,DONE} AND NOT flush); freezes ID/EX and earlier stages.
REQ-011 done  output  1  one-cycle pulse; hi/lo valid.
REQ-012 div_by_zero  output  1  one-cycle pulse coincident with done for DIV/DIVU with rt_data=0.
REQ-013 hi  output  32  MULT: product[63:32]; DIV: remainder.
REQ-014 lo  output  32  MULT: product[31:0]; DIV: quotient.

Function
REQ-015 States IDLE, CALC, SIGN, DONE; DONE lasts exactly one cycle, then IDLE unless new start accepted.
REQ-016 Start accepted in IDLE/DONE when start=1, flush=0; operands, op, and result signs latched in same edge; next state CALC.
REQ-017 CALC runs exactly MDU_CYCLES cycles with a 6-bit down-counter; radix-2 shift-add (multiply) or restoring shift-subtract (divide) on unsigned magnitudes.
REQ-018 Signed ops take two's-complement magnitude of negative operands; 0x80000000 magnitude is 0x80000000 unsigned.
REQ-019 SIGN (1 cycle): negate product if signs differ; negate quotient if signs differ; remainder takes dividend sign; unsigned ops pass through.
REQ-020 hi/lo register update and done=1 occur in DONE; latency start-edge to done = MDU_CYCLES+2 cycles (34 at default).
REQ-021 hi/lo hold value between operations; changed only in DONE.
REQ-022 Divide by zero: full latency kept; lo=0xFFFFFFFF, hi=rs_data as latched; div_by_zero=1 with done.
REQ-023 DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0; no flag.
REQ-024 start while busy ignored; no queuing.
REQ-025 flush in any state: next state IDLE, no done, hi/lo unchanged; flush with start same cycle: start ignored.
REQ-026 Result bits wider than 64 discarded; counter never wraps (loads MDU_CYCLES-1 on accept, CALC exits at 0).

Reset
REQ-027 rst_b=1 at edge: state IDLE, counter 0, hi=0, lo=0, done=0, div_by_zero=0, busy=0; dominates start and flush.
REQ-028 Reset mid-operation discards operation; no done pulse follows.

Structure
REQ-029 Package mdu_pkg holds op encodings, state enum, MDU_CYCLES default; shared with controller and ID/EX-side decode.
REQ-030 Single module; no sub-module; one 64-bit accumulator/remainder register plus 32-bit operand register form datapath.

Verification
REQ-031 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> done at +34 cycles, hi=0xFFFFFFFE, lo=0x00000001, stall_req high cycles 0..33.
REQ-032 MULT 0xFFFFFFFD x 0x00000005 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
REQ-033 DIV 0xFFFFFFF9 / 0x00000002 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-034 DIVU 0x00000064 / 0 -> done and div_by_zero at +34, lo=0xFFFFFFFF, hi=0x00000064.
REQ-035 Flush at CALC cycle 10 -> busy low next cycle, no done, hi/lo retain prior result; start in following cycle accepted, completes normally.
REQ-036 rst_b pulse at CALC cycle 5 -> hi=lo=0, IDLE, no done within 40 cycles; back-to-back start in DONE accepted without IDLE gap.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared encodings and sizing for the multiply/divide unit and its ID/EX-side decode.
package mdu_pkg;

    localparam int unsigned MDU_CYCLES_DEFAULT = 32;
    localparam int unsigned MDU_XLEN           = 32;
    localparam int unsigned MDU_CNT_W          = 6;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'b00,
        MDU_CALC = 2'b01,
        MDU_SIGN = 2'b10,
        MDU_DONE = 2'b11
    } mdu_state_e;

    // True for the two's-complement variants.
    function automatic logic op_is_signed(input mdu_op_e op);
        return (op == MDU_MULT) || (op == MDU_DIV);
    endfunction

    // True for either divide variant.
    function automatic logic op_is_div(input mdu_op_e op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit: radix-2 shift-add multiply, restoring divide,
// operating on magnitudes with a final sign-fixup cycle.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int unsigned MDU_CYCLES = MDU_CYCLES_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_b,
    input  logic                start,
    input  logic [1:0]          op,
    input  logic [MDU_XLEN-1:0] rs_data,
    input  logic [MDU_XLEN-1:0] rt_data,
    input  logic                flush,
    output logic                busy,
    output logic                stall_req,
    output logic                done,
    output logic                div_by_zero,
    output logic [MDU_XLEN-1:0] hi,
    output logic [MDU_XLEN-1:0] lo
);

    localparam int unsigned XW = MDU_XLEN;
    localparam int unsigned AW = 2 * MDU_XLEN;
    localparam logic [MDU_CNT_W-1:0] CNT_LOAD = MDU_CNT_W'(MDU_CYCLES - 1);

    mdu_state_e           state_q, state_d;
    logic [MDU_CNT_W-1:0] cnt_q, cnt_d;
    logic [AW-1:0]        acc_q, acc_d;
    logic [XW-1:0]        opnd_q, opnd_d;
    logic                 is_div_q, is_div_d;
    logic                 neg_res_q, neg_res_d;
    logic                 neg_rem_q, neg_rem_d;
    logic                 dbz_pend_q, dbz_pend_d;
    logic [XW-1:0]        hi_q, hi_d;
    logic [XW-1:0]        lo_q, lo_d;
    logic                 done_q, done_d;
    logic                 dbz_q, dbz_d;
    logic                 busy_q, busy_d;

    mdu_op_e       op_in;
    logic          start_ok;
    logic          rs_neg, rt_neg;
    logic [XW-1:0] rs_mag, rt_mag;
    logic [XW:0]   mul_sum;
    logic [XW:0]   div_diff;

    // Operand decode and the per-iteration adder/subtractor.
    always_comb begin
        op_in    = mdu_op_e'(op);
        start_ok = start && !flush && ((state_q == MDU_IDLE) || (state_q == MDU_DONE));
        rs_neg   = op_is_signed(op_in) && rs_data[XW-1];
        rt_neg   = op_is_signed(op_in) && rt_data[XW-1];
        rs_mag   = rs_neg ? XW'(-rs_data) : rs_data;
        rt_mag   = rt_neg ? XW'(-rt_data) : rt_data;
        mul_sum  = {1'b0, acc_q[AW-1:XW]} + {1'b0, opnd_q};
        // Shifted partial remainder is always below 2*divisor, so 33 bits suffice.
        div_diff = acc_q[AW-1:XW-1] - {1'b0, opnd_q};
    end

    // Next-state and datapath update.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        opnd_d     = opnd_q;
        is_div_d   = is_div_q;
        neg_res_d  = neg_res_q;
        neg_rem_d  = neg_rem_q;
        dbz_pend_d = dbz_pend_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;
        dbz_d      = 1'b0;

        case (state_q)
            MDU_IDLE, MDU_DONE: begin
                state_d = MDU_IDLE;
                if (start_ok) begin
                    state_d    = MDU_CALC;
                    cnt_d      = CNT_LOAD;
                    is_div_d   = op_is_div(op_in);
                    neg_res_d  = rs_neg ^ rt_neg;
                    neg_rem_d  = rs_neg;
                    dbz_pend_d = op_is_div(op_in) && (rt_data == '0);
                    if (op_is_div(op_in)) begin
                        opnd_d = rt_mag;
                        acc_d  = {{XW{1'b0}}, rs_mag};
                    end else begin
                        opnd_d = rs_mag;
                        acc_d  = {{XW{1'b0}}, rt_mag};
                    end
                end
            end
            MDU_CALC: begin
                if (!is_div_q) begin
                    acc_d = acc_q[0] ? {mul_sum, acc_q[XW-1:1]} : {1'b0, acc_q[AW-1:1]};
                end else if (!div_diff[XW]) begin
                    acc_d = {div_diff[XW-1:0], acc_q[XW-2:0], 1'b1};
                end else begin
                    acc_d = {acc_q[AW-2:0], 1'b0};
                end
                if (cnt_q == '0) begin
                    state_d = MDU_SIGN;
                end else begin
                    cnt_d = cnt_q - MDU_CNT_W'(1);
                end
            end
            MDU_SIGN: begin
                state_d = MDU_DONE;
                done_d  = 1'b1;
                dbz_d   = dbz_pend_q;
                if (is_div_q) begin
                    // A zero divisor yields an all-ones quotient regardless of sign.
                    if (dbz_pend_q) begin
                        lo_d = '1;
                    end else begin
                        lo_d = neg_res_q ? XW'(-acc_q[XW-1:0]) : acc_q[XW-1:0];
                    end
                    hi_d = neg_rem_q ? XW'(-acc_q[AW-1:XW]) : acc_q[AW-1:XW];
                end else begin
                    {hi_d, lo_d} = neg_res_q ? AW'(-acc_q) : acc_q;
                end
            end
            default: state_d = MDU_IDLE;
        endcase

        // Squash abandons the operation and leaves the result registers alone.
        if (flush) begin
            state_d = MDU_IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
            done_d  = 1'b0;
            dbz_d   = 1'b0;
        end

        busy_d = (state_d == MDU_CALC) || (state_d == MDU_SIGN);
    end

    // State and result registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst_b) begin
            state_q    <= MDU_IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            opnd_q     <= '0;
            is_div_q   <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            dbz_pend_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
            dbz_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            opnd_q     <= opnd_d;
            is_div_q   <= is_div_d;
            neg_res_q  <= neg_res_d;
            neg_rem_q  <= neg_rem_d;
            dbz_pend_q <= dbz_pend_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            done_q     <= done_d;
            dbz_q      <= dbz_d;
            busy_q     <= busy_d;
        end
    end

    assign busy        = busy_q;
    assign stall_req   = busy_q || start_ok;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: arithmetic vectors, latency, flush and reset behaviour.
module tb_mult_div_unit;

    localparam int unsigned LAT = 34;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        flush;
    logic        busy;
    logic        stall_req;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    mult_div_unit #(.MDU_CYCLES(32)) dut (
        .clk         (clk),
        .rst_b       (rst_b),
        .start       (start),
        .op          (op),
        .rs_data     (rs_data),
        .rt_data     (rt_data),
        .flush       (flush),
        .busy        (busy),
        .stall_req   (stall_req),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    always #5 clk = ~clk;

    // Issue one op at the current negedge (cycle 0) and check every cycle up to done.
    // Returns at the negedge of the DONE cycle, so a following call starts back-to-back.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo, input logic edbz,
                          input bit hold_start, input string name);
        op = o; rs_data = a; rt_data = b; start = 1'b1; flush = 1'b0;
        #1;
        checks++;
        if (stall_req !== 1'b1) begin
            errors++; $display("FAIL %s stall_c0: got %b want 1", name, stall_req);
        end
        @(negedge clk);
        for (int c = 1; c < LAT; c++) begin
            checks++;
            if (stall_req !== 1'b1 || busy !== 1'b1) begin
                errors++; $display("FAIL %s busy_c%0d: stall=%b busy=%b want 1/1", name, c, stall_req, busy);
            end
            checks++;
            if (done !== 1'b0 || div_by_zero !== 1'b0) begin
                errors++; $display("FAIL %s early_done_c%0d: done=%b dbz=%b want 0/0", name, c, done, div_by_zero);
            end
            checks++;
            if (hi !== m_hi || lo !== m_lo) begin
                errors++; $display("FAIL %s hold_c%0d: hi=%h lo=%h want %h %h", name, c, hi, lo, m_hi, m_lo);
            end
            if (c == 1) begin
                start   = hold_start;
                op      = 2'b11;
                rs_data = 32'd100;
                rt_data = 32'd3;
            end
            if (c == LAT - 1) start = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (done !== 1'b1) begin
            errors++; $display("FAIL %s done: got %b want 1", name, done);
        end
        checks++;
        if (div_by_zero !== edbz) begin
            errors++; $display("FAIL %s dbz: got %b want %b", name, div_by_zero, edbz);
        end
        checks++;
        if (hi !== ehi) begin
            errors++; $display("FAIL %s hi: got %h want %h", name, hi, ehi);
        end
        checks++;
        if (lo !== elo) begin
            errors++; $display("FAIL %s lo: got %h want %h", name, lo, elo);
        end
        checks++;
        if (busy !== 1'b0 || stall_req !== 1'b0) begin
            errors++; $display("FAIL %s done_idle: busy=%b stall=%b want 0/0", name, busy, stall_req);
        end
        m_hi = ehi;
        m_lo = elo;
    endtask

    task automatic test_reset();
        rst_b = 1'b1; start = 1'b0; flush = 1'b0; op = 2'b00; rs_data = '0; rt_data = '0;
        repeat (3) @(negedge clk);
        start = 1'b1; op = 2'b01; rs_data = 32'd9; rt_data = 32'd9;
        @(negedge clk);
        checks++;
        if (hi !== 32'h0 || lo !== 32'h0) begin
            errors++; $display("FAIL reset_hilo: hi=%h lo=%h want 0 0", hi, lo);
        end
        checks++;
        if (done !== 1'b0 || div_by_zero !== 1'b0) begin
            errors++; $display("FAIL reset_flags: done=%b dbz=%b want 0/0", done, div_by_zero);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL reset_busy: got %b want 0", busy);
        end
        start = 1'b0; rst_b = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || stall_req !== 1'b0) begin
            errors++; $display("FAIL reset_idle: busy=%b stall=%b want 0/0", busy, stall_req);
        end
        m_hi = '0; m_lo = '0;
    endtask

    task automatic test_multu();
        run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b0, "multu_max");
        run_op(2'b01, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0, 1'b0, "multu_shift");
    endtask

    task automatic test_mult();
        run_op(2'b00, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 1'b0, "mult_neg");
        run_op(2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 1'b0, "mult_minmin");
    endtask

    task automatic test_div();
        run_op(2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b0, "div_neg");
        run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 1'b0, "div_ovf");
        run_op(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b0, "divu_rem");
    endtask

    task automatic test_div_by_zero();
        run_op(2'b11, 32'h00000064, 32'h0, 32'h00000064, 32'hFFFFFFFF, 1'b1, 1'b0, "divu_zero");
        run_op(2'b10, 32'hFFFFFFF0, 32'h0, 32'hFFFFFFF0, 32'hFFFFFFFF, 1'b1, 1'b0, "div_zero");
    endtask

    task automatic test_start_ignored();
        run_op(2'b01, 32'd7, 32'd6, 32'd0, 32'd42, 1'b0, 1'b1, "start_busy");
    endtask

    task automatic test_hold();
        bit bad = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (hi !== m_hi || lo !== m_lo || done !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++; $display("FAIL hold_idle: hi=%h lo=%h done=%b want %h %h 0", hi, lo, done, m_hi, m_lo);
        end
    endtask

    task automatic test_flush();
        op = 2'b01; rs_data = 32'd3; rt_data = 32'd4; start = 1'b1; flush = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL flush_pre_busy: got %b want 1", busy);
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL flush_busy: busy=%b done=%b want 0/0", busy, done);
        end
        checks++;
        if (hi !== m_hi || lo !== m_lo) begin
            errors++; $display("FAIL flush_hold: hi=%h lo=%h want %h %h", hi, lo, m_hi, m_lo);
        end
        run_op(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b0, "after_flush");
    endtask

    task automatic test_flush_with_start();
        bit saw_done = 1'b0;
        @(negedge clk);
        op = 2'b01; rs_data = 32'd5; rt_data = 32'd5; start = 1'b1; flush = 1'b1;
        #1;
        checks++;
        if (stall_req !== 1'b0) begin
            errors++; $display("FAIL flush_start_stall: got %b want 0", stall_req);
        end
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL flush_start_busy: got %b want 0", busy);
        end
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done !== 1'b0) saw_done = 1'b1;
        end
        checks++;
        if (saw_done || hi !== m_hi || lo !== m_lo) begin
            errors++; $display("FAIL flush_start_nodone: saw_done=%b hi=%h lo=%h want 0 %h %h", saw_done, hi, lo, m_hi, m_lo);
        end
    endtask

    task automatic test_reset_mid();
        bit saw_done = 1'b0;
        op = 2'b00; rs_data = 32'd5; rt_data = 32'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);
        rst_b = 1'b0;
        checks++;
        if (hi !== 32'h0 || lo !== 32'h0) begin
            errors++; $display("FAIL rst_mid_hilo: hi=%h lo=%h want 0 0", hi, lo);
        end
        checks++;
        if (busy !== 1'b0 || stall_req !== 1'b0) begin
            errors++; $display("FAIL rst_mid_idle: busy=%b stall=%b want 0/0", busy, stall_req);
        end
        m_hi = '0; m_lo = '0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done !== 1'b0) saw_done = 1'b1;
        end
        checks++;
        if (saw_done) begin
            errors++; $display("FAIL rst_mid_nodone: saw_done=%b want 0", saw_done);
        end
    endtask

    task automatic test_back_to_back();
        run_op(2'b00, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 1'b0, "b2b_1");
        run_op(2'b11, 32'h00000064, 32'h0, 32'h00000064, 32'hFFFFFFFF, 1'b1, 1'b0, "b2b_2");
        run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 1'b0, "b2b_3");
        start = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_multu();
        test_mult();
        test_div();
        test_div_by_zero();
        test_start_ignored();
        test_hold();
        test_flush();
        test_flush_with_start();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
